// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman bit-serial link (encoder and decoder sides).
// Holds the code table and the encoder state record.
package huffman_pkg;

    localparam int NUM_SYMBOLS = 18;
    localparam int SYM_W       = 5;
    localparam int MAX_LEN     = 8;

    typedef logic [SYM_W-1:0]   sym_t;
    typedef logic [MAX_LEN-1:0] code_t;   // code left-aligned, unused low bits zero
    typedef logic [3:0]         len_t;    // 0..MAX_LEN

    typedef struct packed {
        code_t code;
        len_t  len;
        logic  illegal;
    } huff_entry_t;

    // Per-edge decision of what the shifter/pending pair does with new data.
    typedef enum logic [1:0] {
        LOAD_NONE,
        LOAD_PEND,
        LOAD_BYPASS,
        LOAD_STORE
    } load_kind_t;

    typedef struct packed {
        code_t shifter;
        len_t  rem;
        code_t pend_code;
        len_t  pend_len;
        logic  pend_valid;
        logic  err;
    } enc_state_t;

    function automatic huff_entry_t huff_lookup(input sym_t sym);
        huff_entry_t e;
        e.code    = '0;
        e.len     = '0;
        e.illegal = (sym == '0) || (int'(sym) > NUM_SYMBOLS);
        case (sym)
            5'd1:    begin e.code = 8'b0000_0000; e.len = 4'd2; end
            5'd2:    begin e.code = 8'b0100_0000; e.len = 4'd2; end
            5'd3:    begin e.code = 8'b1000_0000; e.len = 4'd2; end
            5'd4:    begin e.code = 8'b1100_0000; e.len = 4'd3; end
            5'd5:    begin e.code = 8'b1110_0000; e.len = 4'd6; end
            5'd6:    begin e.code = 8'b1110_0100; e.len = 4'd6; end
            5'd7:    begin e.code = 8'b1110_1000; e.len = 4'd6; end
            5'd8:    begin e.code = 8'b1110_1100; e.len = 4'd7; end
            5'd9:    begin e.code = 8'b1110_1110; e.len = 4'd7; end
            5'd10:   begin e.code = 8'b1111_0000; e.len = 4'd7; end
            5'd11:   begin e.code = 8'b1111_0010; e.len = 4'd7; end
            5'd12:   begin e.code = 8'b1111_0100; e.len = 4'd7; end
            5'd13:   begin e.code = 8'b1111_0110; e.len = 4'd7; end
            5'd14:   begin e.code = 8'b1111_1000; e.len = 4'd7; end
            5'd15:   begin e.code = 8'b1111_1010; e.len = 4'd7; end
            5'd16:   begin e.code = 8'b1111_1100; e.len = 4'd7; end
            5'd17:   begin e.code = 8'b1111_1110; e.len = 4'd8; end
            5'd18:   begin e.code = 8'b1111_1111; e.len = 4'd8; end
            default: begin e.code = '0;           e.len = '0;   end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/huffman_encoder_if.sv
// Symbol-in / bit-out bus of the Huffman encoder.
// The master side supplies symbols and watches the serial stream.
interface huffman_encoder_if;
    import huffman_pkg::*;

    sym_t in_sym;
    logic in_valid;
    logic in_ready;
    logic out;
    logic out_valid;
    logic sym_done;
    logic err;

    modport master (
        output in_sym, in_valid,
        input  in_ready, out, out_valid, sym_done, err
    );

    modport slave (
        input  in_sym, in_valid,
        output in_ready, out, out_valid, sym_done, err
    );

endinterface

// File: rtl/huffman_code_rom.sv
// Combinational symbol -> (left-aligned code, length, illegal) lookup.
module huffman_code_rom
    import huffman_pkg::*;
(
    input  sym_t  sym,
    output code_t code,
    output len_t  len,
    output logic  illegal
);

    huff_entry_t entry;

    always_comb begin
        entry = huff_lookup(sym);
    end

    assign code    = entry.code;
    assign len     = entry.len;
    assign illegal = entry.illegal;

endmodule

// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: one symbol in per handshake, code bits out MSB-first,
// with a one-entry pending buffer so consecutive codes stream without gaps.
module huffman_encoder
    import huffman_pkg::*;
#(
    parameter logic IDLE_BIT = 1'b0
) (
    input logic clk,
    input logic reset,
    huffman_encoder_if.slave bus
);

    enc_state_t st;
    enc_state_t st_nxt;
    load_kind_t load;

    code_t rom_code;
    len_t  rom_len;
    logic  rom_illegal;
    logic  xfer;
    logic  free;

    huffman_code_rom u_rom (
        .sym     (bus.in_sym),
        .code    (rom_code),
        .len     (rom_len),
        .illegal (rom_illegal)
    );

    // in_ready depends on registered state only, so xfer has no in_valid->in_ready loop.
    assign xfer = bus.in_valid && !st.pend_valid;
    assign free = (st.rem <= len_t'(1));

    always_comb begin
        // NOTE: the whole next-state record defaults to the current state first, so no latch is inferred.
        st_nxt     = st;
        st_nxt.err = xfer && rom_illegal;

        load = LOAD_NONE;
        if (free && st.pend_valid) begin
            load = LOAD_PEND;
        end else if (xfer && !rom_illegal) begin
            load = free ? LOAD_BYPASS : LOAD_STORE;
        end

        if (st.rem != '0) begin
            st_nxt.shifter = st.shifter << 1;
            st_nxt.rem     = st.rem - 4'd1;
        end

        unique case (load)
            LOAD_PEND: begin
                st_nxt.shifter    = st.pend_code;
                st_nxt.rem        = st.pend_len;
                st_nxt.pend_valid = 1'b0;
            end
            LOAD_BYPASS: begin
                st_nxt.shifter = rom_code;
                st_nxt.rem     = rom_len;
            end
            LOAD_STORE: begin
                st_nxt.pend_code  = rom_code;
                st_nxt.pend_len   = rom_len;
                st_nxt.pend_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the pending buffer is a single register, so it is cleared with the rest of the state.
            st <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            st <= st_nxt;
        end
    end

    assign bus.in_ready  = !st.pend_valid;
    assign bus.out_valid = (st.rem != '0);
    assign bus.out       = (st.rem != '0) ? st.shifter[MAX_LEN-1] : IDLE_BIT;
    assign bus.sym_done  = (st.rem == len_t'(1));
    assign bus.err       = st.err;

endmodule
